// File: rtl/asi_pkg.sv
// Shared ASI definitions: burst type codes, legal WRAP lengths, scheduler state
// type, burst descriptor layout and the descriptor legality check.
package asi_pkg;

   localparam int ASI_AW     = 40;
   localparam int ASI_LW     = 8;
   localparam int ASI_SW     = 3;
   localparam int ASI_BURSTW = 2;

   localparam logic [ASI_BURSTW-1:0] BT_FIXED    = 2'd0;
   localparam logic [ASI_BURSTW-1:0] BT_INCR     = 2'd1;
   localparam logic [ASI_BURSTW-1:0] BT_WRAP     = 2'd2;
   localparam logic [ASI_BURSTW-1:0] BT_RESERVED = 2'd3;

   localparam logic [ASI_LW-1:0] WRAP_BL_2  = 8'd1;
   localparam logic [ASI_LW-1:0] WRAP_BL_4  = 8'd3;
   localparam logic [ASI_LW-1:0] WRAP_BL_8  = 8'd7;
   localparam logic [ASI_LW-1:0] WRAP_BL_16 = 8'd15;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WBURST = 2'd1,
      ST_RBURST = 2'd2
   } asi_sched_st_e;

   typedef struct packed {
      logic [ASI_AW-1:0]     addr;
      logic [ASI_LW-1:0]     len;
      logic [ASI_SW-1:0]     size;
      logic [ASI_BURSTW-1:0] burst;
   } asi_burst_desc_t;

   // Reserved burst type, or WRAP with a length other than 2/4/8/16 beats.
   function automatic logic desc_illegal(input logic [ASI_BURSTW-1:0] burst,
                                         input logic [ASI_LW-1:0]     len);
      logic bad;
      bad = 1'b0;
      case (burst)
         BT_RESERVED: bad = 1'b1;
         BT_WRAP:     bad = !((len == WRAP_BL_2) || (len == WRAP_BL_4) ||
                              (len == WRAP_BL_8) || (len == WRAP_BL_16));
         default:     bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/asi_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts, modulo 2^AXI_AW.
module asi_addr_gen
   import asi_pkg::*;
#(
   parameter int AXI_AW     = ASI_AW,
   parameter int AXI_LW     = ASI_LW,
   parameter int AXI_SW     = ASI_SW,
   parameter int AXI_BURSTW = ASI_BURSTW
) (
   input  logic [AXI_AW-1:0]     addr,
   input  logic [AXI_SW-1:0]     size,
   input  logic [AXI_LW-1:0]     len,
   input  logic [AXI_BURSTW-1:0] burst,
   output logic [AXI_AW-1:0]     next_addr
);

   localparam logic [AXI_AW-1:0] ONE = AXI_AW'(1);

   logic [AXI_AW-1:0] inc_s;
   logic [AXI_AW-1:0] bound_s;
   logic [AXI_AW-1:0] incr_s;
   logic [AXI_AW-1:0] wrap_s;

   // INCR aligns down then steps; WRAP keeps the bits above the wrap boundary.
   always_comb begin
      inc_s   = ONE << size;
      bound_s = ({{(AXI_AW-AXI_LW){1'b0}}, len} + ONE) << size;
      incr_s  = (addr & ~(inc_s - ONE)) + inc_s;
      wrap_s  = (addr & ~(bound_s - ONE)) | ((addr + inc_s) & (bound_s - ONE));
      case (burst)
         BT_FIXED: next_addr = addr;
         BT_INCR:  next_addr = incr_s;
         BT_WRAP:  next_addr = wrap_s;
         default:  next_addr = incr_s;
      endcase
   end

endmodule

// File: rtl/asi_rw_sched.sv
// Burst-level scheduler sharing the single-port ASI memory between write and read
// paths: tie-break arbitration with starvation guard, then beat sequencing.
module asi_rw_sched
   import asi_pkg::*;
#(
   parameter int AXI_AW     = ASI_AW,
   parameter int AXI_LW     = ASI_LW,
   parameter int AXI_SW     = ASI_SW,
   parameter int AXI_BURSTW = ASI_BURSTW,
   parameter int SLV_ARB    = 0,
   parameter int STARVE_N   = 4
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  wreq_valid,
   output logic                  wreq_ready,
   input  logic [AXI_AW-1:0]     wreq_addr,
   input  logic [AXI_LW-1:0]     wreq_len,
   input  logic [AXI_SW-1:0]     wreq_size,
   input  logic [AXI_BURSTW-1:0] wreq_burst,
   input  logic                  rreq_valid,
   output logic                  rreq_ready,
   input  logic [AXI_AW-1:0]     rreq_addr,
   input  logic [AXI_LW-1:0]     rreq_len,
   input  logic [AXI_SW-1:0]     rreq_size,
   input  logic [AXI_BURSTW-1:0] rreq_burst,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [AXI_AW-1:0]     mem_addr,
   output logic                  mem_last,
   input  logic                  mem_ready,
   output logic                  busy_w,
   output logic                  busy_r,
   output logic                  rsv_err
);

   localparam int STW = (STARVE_N < 1) ? 1 : $clog2(STARVE_N + 1);
   localparam logic [STW-1:0] STARVE_MAX = STW'(STARVE_N);
   localparam logic [STW-1:0] STARVE_ONE = STW'(1);
   localparam logic READ_PRI = (SLV_ARB != 0);

   asi_sched_st_e state_r;
   asi_sched_st_e state_s;

   asi_burst_desc_t desc_r;
   asi_burst_desc_t sel_desc_s;

   logic [AXI_AW-1:0]     addr_r;
   logic [AXI_AW-1:0]     next_addr_s;
   logic [AXI_LW-1:0]     beat_cnt_r;
   logic [STW-1:0]        starve_r;
   logic                  last_r;
   logic                  rsv_err_r;

   logic                  tie_s;
   logic                  forced_s;
   logic                  grant_w_s;
   logic                  grant_r_s;
   logic                  accept_s;
   logic                  pri_won_s;
   logic                  illegal_s;
   logic                  xfer_s;
   logic [AXI_BURSTW-1:0] raw_burst_s;
   logic [AXI_LW-1:0]     raw_len_s;

   // Arbitration: a tie goes to the priority side unless it has starved the other.
   always_comb begin
      tie_s     = wreq_valid & rreq_valid;
      forced_s  = (starve_r == STARVE_MAX);
      grant_w_s = 1'b0;
      grant_r_s = 1'b0;
      if ((state_r == ST_IDLE) && !ARESET) begin
         if (tie_s) begin
            if (READ_PRI ^ forced_s) begin
               grant_r_s = 1'b1;
            end else begin
               grant_w_s = 1'b1;
            end
         end else begin
            grant_w_s = wreq_valid;
            grant_r_s = rreq_valid;
         end
      end else begin
         grant_w_s = 1'b0;
         grant_r_s = 1'b0;
      end
      accept_s  = grant_w_s | grant_r_s;
      pri_won_s = tie_s & (READ_PRI ? grant_r_s : grant_w_s);
   end

   // Descriptor mux; illegal descriptors are demoted to INCR before registering.
   always_comb begin
      raw_burst_s      = grant_w_s ? wreq_burst : rreq_burst;
      raw_len_s        = grant_w_s ? wreq_len : rreq_len;
      illegal_s        = desc_illegal(raw_burst_s, raw_len_s);
      sel_desc_s.addr  = grant_w_s ? wreq_addr : rreq_addr;
      sel_desc_s.len   = raw_len_s;
      sel_desc_s.size  = grant_w_s ? wreq_size : rreq_size;
      sel_desc_s.burst = illegal_s ? BT_INCR : raw_burst_s;
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (grant_w_s) begin
               state_s = ST_WBURST;
            end else if (grant_r_s) begin
               state_s = ST_RBURST;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WBURST, ST_RBURST: begin
            if (mem_ready && last_r) begin
               state_s = ST_IDLE;
            end else begin
               state_s = state_r;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   assign xfer_s = (state_r != ST_IDLE) & mem_ready;

   // Burst datapath: descriptor capture, beat counting, address stepping, starvation count.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         desc_r     <= '0;
         addr_r     <= '0;
         beat_cnt_r <= '0;
         last_r     <= 1'b0;
         rsv_err_r  <= 1'b0;
         starve_r   <= '0;
      end else begin
         rsv_err_r <= accept_s & illegal_s;
         if (accept_s) begin
            desc_r     <= sel_desc_s;
            addr_r     <= sel_desc_s.addr;
            beat_cnt_r <= '0;
            last_r     <= (sel_desc_s.len == '0);
            if (pri_won_s) begin
               starve_r <= forced_s ? starve_r : starve_r + STARVE_ONE;
            end else begin
               starve_r <= '0;
            end
         end else if (xfer_s) begin
            if (last_r) begin
               last_r <= 1'b0;
            end else begin
               beat_cnt_r <= beat_cnt_r + AXI_LW'(1);
               addr_r     <= next_addr_s;
               last_r     <= ((beat_cnt_r + AXI_LW'(1)) == desc_r.len);
            end
         end
      end
   end

   asi_addr_gen #(
      .AXI_AW     (AXI_AW),
      .AXI_LW     (AXI_LW),
      .AXI_SW     (AXI_SW),
      .AXI_BURSTW (AXI_BURSTW)
   ) u_addr_gen (
      .addr      (addr_r),
      .size      (desc_r.size),
      .len       (desc_r.len),
      .burst     (desc_r.burst),
      .next_addr (next_addr_s)
   );

   assign wreq_ready = grant_w_s;
   assign rreq_ready = grant_r_s;
   assign mem_en     = (state_r != ST_IDLE);
   assign mem_we     = (state_r == ST_WBURST);
   assign mem_addr   = addr_r;
   assign mem_last   = last_r;
   assign busy_w     = (state_r == ST_WBURST);
   assign busy_r     = (state_r == ST_RBURST);
   assign rsv_err    = rsv_err_r;

endmodule

// File: tb/tb_asi_rw_sched.sv
// Self-checking bench for asi_rw_sched: directed scenarios plus randomized bursts
// checked against closed-form beat-address and arbitration models.
module tb_asi_rw_sched;
   import asi_pkg::*;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        wreq_valid, rreq_valid, wreq_ready, rreq_ready;
   logic [39:0] wreq_addr, rreq_addr, mem_addr;
   logic [7:0]  wreq_len, rreq_len;
   logic [2:0]  wreq_size, rreq_size;
   logic [1:0]  wreq_burst, rreq_burst;
   logic        mem_en, mem_we, mem_last, mem_ready, busy_w, busy_r, rsv_err;

   int nvec = 0;
   int nerr = 0;

   logic [39:0] obs_addr [0:63];
   logic        obs_we   [0:63];
   logic        obs_last [0:63];
   int          obs_n, obs_rsv, obs_hold_err;
   logic        obs_accepted, obs_first_en, obs_rsv_first, obs_timeout, obs_idle_after;
   bit          ready_pat[$];

   always #5 ACLK = ~ACLK;

   asi_rw_sched #(.SLV_ARB(0), .STARVE_N(4)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .wreq_valid(wreq_valid), .wreq_ready(wreq_ready), .wreq_addr(wreq_addr),
      .wreq_len(wreq_len), .wreq_size(wreq_size), .wreq_burst(wreq_burst),
      .rreq_valid(rreq_valid), .rreq_ready(rreq_ready), .rreq_addr(rreq_addr),
      .rreq_len(rreq_len), .rreq_size(rreq_size), .rreq_burst(rreq_burst),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_last(mem_last),
      .mem_ready(mem_ready), .busy_w(busy_w), .busy_r(busy_r), .rsv_err(rsv_err)
   );

   function automatic bit exp_illegal(input logic [1:0] b, input int l);
      return (b == BT_RESERVED) || (b == BT_WRAP && l != 1 && l != 3 && l != 7 && l != 15);
   endfunction

   // Address of beat i, in closed form from the start address.
   function automatic logic [39:0] exp_addr(input logic [39:0] a, input int l, input int s,
                                            input logic [1:0] b, input int i);
      longint unsigned av, inc, bound, iu, r;
      logic [1:0] eb;
      av = {24'd0, a};
      iu = longint'(i);
      inc = 64'd1 << s;
      eb = exp_illegal(b, l) ? BT_INCR : b;
      if (eb == BT_FIXED || i == 0) r = av;
      else if (eb == BT_WRAP) begin
         bound = inc * longint'(l + 1);
         r = (av - (av % bound)) + ((av + inc * iu) % bound);
      end else r = (av - (av % inc)) + inc * iu;
      return r[39:0];
   endfunction

   function automatic logic next_ready(input int pct);
      if (ready_pat.size() > 0) return ready_pat.pop_front();
      else if (pct > 0 && int'($urandom_range(99, 0)) < pct) return 1'b0;
      else return 1'b1;
   endfunction

   // Drive one descriptor and record every transferred beat; call just after a posedge.
   task automatic do_burst(input bit is_w, input logic [39:0] a, input int l, input int s,
                           input logic [1:0] b, input int pct);
      logic [39:0] held_addr;
      logic held_last, stalled, done;
      held_addr = '0; held_last = 1'b0; stalled = 1'b0; done = 1'b0;
      if (is_w) begin
         wreq_valid = 1'b1; wreq_addr = a; wreq_len = 8'(l); wreq_size = 3'(s); wreq_burst = b;
      end else begin
         rreq_valid = 1'b1; rreq_addr = a; rreq_len = 8'(l); rreq_size = 3'(s); rreq_burst = b;
      end
      @(negedge ACLK);
      obs_accepted = is_w ? wreq_ready : rreq_ready;
      @(posedge ACLK); #1;
      wreq_valid = 1'b0; rreq_valid = 1'b0;
      obs_n = 0; obs_rsv = 0; obs_hold_err = 0; obs_timeout = 1'b0;
      mem_ready = next_ready(pct);
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge ACLK);
         if (cyc == 0) begin obs_first_en = mem_en; obs_rsv_first = rsv_err; end
         if (rsv_err) obs_rsv++;
         if (stalled && (mem_en !== 1'b1 || mem_addr !== held_addr || mem_last !== held_last))
            obs_hold_err++;
         if (mem_en && mem_ready) begin
            if (obs_n < 64) begin
               obs_addr[obs_n] = mem_addr; obs_we[obs_n] = mem_we; obs_last[obs_n] = mem_last;
            end
            obs_n++;
            stalled = 1'b0;
            if (mem_last || obs_n >= 64) done = 1'b1;
         end else if (mem_en) begin
            stalled = 1'b1; held_addr = mem_addr; held_last = mem_last;
         end else stalled = 1'b0;
         @(posedge ACLK); #1;
         if (done) break;
         mem_ready = next_ready(pct);
      end
      obs_timeout = !done;
      mem_ready = 1'b1;
      @(negedge ACLK);
      obs_idle_after = !mem_en && !busy_w && !busy_r;
      @(posedge ACLK); #1;
   endtask

   task automatic test_reset();
      wreq_valid = 1'b1; rreq_valid = 1'b1;
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      nvec++;
      if ({wreq_ready, rreq_ready, mem_en, mem_we, mem_last, busy_w, busy_r, rsv_err} !== 8'b0) begin
         nerr++;
         $display("FAIL reset_outputs: got %b required 00000000",
                  {wreq_ready, rreq_ready, mem_en, mem_we, mem_last, busy_w, busy_r, rsv_err});
      end
      nvec++;
      if (mem_addr !== 40'h0) begin nerr++; $display("FAIL reset_addr: got %h required 0", mem_addr); end
      @(posedge ACLK); #1;
      wreq_valid = 1'b0; rreq_valid = 1'b0; ARESET = 1'b0;
      @(negedge ACLK);
      nvec++;
      if (mem_en !== 1'b0) begin nerr++; $display("FAIL reset_release_idle: mem_en=%b required 0", mem_en); end
      @(posedge ACLK); #1;
   endtask

   task automatic test_incr_write();
      logic [39:0] want [0:3];
      want[0] = 40'h100; want[1] = 40'h110; want[2] = 40'h120; want[3] = 40'h130;
      do_burst(1'b1, 40'h100, 3, 4, BT_INCR, 0);
      nvec++;
      if (obs_n !== 4) begin nerr++; $display("FAIL incr_write_beats: got %0d required 4", obs_n); end
      for (int i = 0; i < 4 && i < obs_n; i++) begin
         nvec++;
         if ({obs_we[i], obs_last[i], obs_addr[i]} !== {1'b1, (i == 3), want[i]}) begin
            nerr++;
            $display("FAIL incr_write_beat%0d: got we=%b last=%b addr=%h required we=1 last=%b addr=%h",
                     i, obs_we[i], obs_last[i], obs_addr[i], (i == 3), want[i]);
         end
      end
      nvec++;
      if ({obs_accepted, obs_first_en, obs_timeout, obs_idle_after, obs_rsv == 0} !== 5'b11011) begin
         nerr++;
         $display("FAIL incr_write_ctrl: got %b required 11011",
                  {obs_accepted, obs_first_en, obs_timeout, obs_idle_after, obs_rsv == 0});
      end
   endtask

   task automatic test_wrap_read();
      logic [39:0] want [0:3];
      want[0] = 40'h38; want[1] = 40'h20; want[2] = 40'h28; want[3] = 40'h30;
      do_burst(1'b0, 40'h38, 3, 3, BT_WRAP, 0);
      nvec++;
      if (obs_n !== 4) begin nerr++; $display("FAIL wrap_read_beats: got %0d required 4", obs_n); end
      for (int i = 0; i < 4 && i < obs_n; i++) begin
         nvec++;
         if ({obs_we[i], obs_last[i], obs_addr[i]} !== {1'b0, (i == 3), want[i]}) begin
            nerr++;
            $display("FAIL wrap_read_beat%0d: got we=%b last=%b addr=%h required we=0 last=%b addr=%h",
                     i, obs_we[i], obs_last[i], obs_addr[i], (i == 3), want[i]);
         end
      end
      nvec++;
      if (obs_rsv !== 0) begin nerr++; $display("FAIL wrap_read_rsv: got %0d pulses required 0", obs_rsv); end
   endtask

   task automatic test_arbitration();
      bit g[$];
      int gcyc[$];
      int dbl, wins;
      bit exp_w;
      dbl = 0; wins = 0;
      wreq_addr = 40'h10; wreq_len = 8'd0; wreq_size = 3'd0; wreq_burst = BT_INCR;
      rreq_addr = 40'h20; rreq_len = 8'd0; rreq_size = 3'd0; rreq_burst = BT_INCR;
      mem_ready = 1'b1; wreq_valid = 1'b1; rreq_valid = 1'b1;
      for (int cyc = 0; cyc < 100 && g.size() < 10; cyc++) begin
         @(negedge ACLK);
         if (wreq_ready && rreq_ready) dbl++;
         if (wreq_ready) begin g.push_back(1'b1); gcyc.push_back(cyc); end
         else if (rreq_ready) begin g.push_back(1'b0); gcyc.push_back(cyc); end
         @(posedge ACLK); #1;
      end
      wreq_valid = 1'b0; rreq_valid = 1'b0;
      nvec++;
      if (g.size() != 10 || dbl != 0) begin
         nerr++; $display("FAIL arb_grants: got %0d grants (%0d double) required 10 (0)", g.size(), dbl);
      end
      for (int i = 0; i < g.size(); i++) begin
         exp_w = (wins < 4);
         wins = exp_w ? wins + 1 : 0;
         nvec++;
         if (g[i] !== exp_w) begin
            nerr++; $display("FAIL arb_order%0d: got write=%b required write=%b", i, g[i], exp_w);
         end
         if (i > 0) begin
            nvec++;
            if (gcyc[i] - gcyc[i-1] != 2) begin
               nerr++; $display("FAIL arb_spacing%0d: got %0d cycles required 2", i, gcyc[i] - gcyc[i-1]);
            end
         end
      end
      repeat (4) @(posedge ACLK);
      #1;
   endtask

   task automatic test_wraparound();
      do_burst(1'b1, 40'hFF_FFFF_FFF0, 1, 4, BT_INCR, 0);
      nvec++;
      if (obs_n !== 2 || obs_addr[0] !== 40'hFF_FFFF_FFF0 || obs_addr[1] !== 40'h0) begin
         nerr++;
         $display("FAIL wraparound: got n=%0d %h %h required n=2 fffffffff0 0000000000",
                  obs_n, obs_addr[0], obs_addr[1]);
      end
   endtask

   task automatic test_stall();
      ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      do_burst(1'b1, 40'h400, 2, 2, BT_FIXED, 0);
      nvec++;
      if (obs_n !== 3) begin nerr++; $display("FAIL stall_transfers: got %0d required 3", obs_n); end
      nvec++;
      if (obs_hold_err !== 0) begin nerr++; $display("FAIL stall_hold: got %0d unstable cycles required 0", obs_hold_err); end
      for (int i = 0; i < 3 && i < obs_n; i++) begin
         nvec++;
         if ({obs_last[i], obs_addr[i]} !== {(i == 2), 40'h400}) begin
            nerr++;
            $display("FAIL stall_beat%0d: got last=%b addr=%h required last=%b addr=400",
                     i, obs_last[i], obs_addr[i], (i == 2));
         end
      end
   endtask

   task automatic test_illegal();
      for (int k = 0; k < 2; k++) begin
         if (k == 0) do_burst(1'b1, 40'h204, 2, 2, BT_RESERVED, 0);
         else        do_burst(1'b0, 40'h30C, 2, 3, BT_WRAP, 0);
         nvec++;
         if ({obs_rsv_first, obs_rsv == 1, obs_n == 3} !== 3'b111) begin
            nerr++;
            $display("FAIL illegal%0d_rsv: got first=%b pulses=%0d beats=%0d required 1 1 3",
                     k, obs_rsv_first, obs_rsv, obs_n);
         end
         for (int i = 0; i < 3 && i < obs_n; i++) begin
            nvec++;
            if (obs_addr[i] !== exp_addr(k == 0 ? 40'h204 : 40'h30C, 2, k == 0 ? 2 : 3, BT_INCR, i)) begin
               nerr++;
               $display("FAIL illegal%0d_beat%0d: got %h required %h", k, i, obs_addr[i],
                        exp_addr(k == 0 ? 40'h204 : 40'h30C, 2, k == 0 ? 2 : 3, BT_INCR, i));
            end
         end
      end
   endtask

   task automatic test_random();
      logic [63:0] r64;
      logic [39:0] a;
      logic [1:0]  b;
      int l, s, bad;
      bit is_w, er;
      for (int t = 0; t < 40; t++) begin
         r64 = {$urandom(), $urandom()};
         a = r64[39:0];
         l = int'($urandom_range(15, 0));
         s = int'($urandom_range(4, 0));
         b = 2'($urandom_range(3, 0));
         is_w = 1'($urandom_range(1, 0));
         er = exp_illegal(b, l);
         do_burst(is_w, a, l, s, b, 30);
         nvec++;
         if ({obs_accepted, obs_first_en, obs_timeout, obs_idle_after, obs_hold_err == 0,
              obs_rsv == int'(er), obs_rsv_first, obs_n == l + 1} !== {5'b11011, 1'b1, er, 1'b1}) begin
            nerr++;
            $display("FAIL rand%0d_ctrl: acc=%b first=%b tmo=%b idle=%b hold=%0d rsv=%0d/%b n=%0d required rsv=%b n=%0d",
                     t, obs_accepted, obs_first_en, obs_timeout, obs_idle_after, obs_hold_err,
                     obs_rsv, obs_rsv_first, obs_n, er, l + 1);
         end
         bad = 0;
         for (int i = 0; i < obs_n && i < 64; i++)
            if ({obs_we[i], obs_last[i], obs_addr[i]} !== {is_w, (i == l), exp_addr(a, l, s, b, i)}) bad++;
         nvec++;
         if (bad != 0) begin
            nerr++;
            $display("FAIL rand%0d_beats: got %0d wrong beats required 0 (a=%h l=%0d s=%0d b=%0d w=%b)",
                     t, bad, a, l, s, b, is_w);
         end
      end
   endtask

   task automatic test_reset_midburst();
      int replay;
      replay = 0;
      mem_ready = 1'b1;
      wreq_addr = 40'h1000; wreq_len = 8'd3; wreq_size = 3'd2; wreq_burst = BT_INCR; wreq_valid = 1'b1;
      @(negedge ACLK);
      @(posedge ACLK); #1;
      wreq_valid = 1'b0;
      repeat (2) begin @(posedge ACLK); #1; end
      ARESET = 1'b1;
      rreq_addr = 40'h80; rreq_len = 8'd0; rreq_size = 3'd0; rreq_burst = BT_INCR; rreq_valid = 1'b1;
      @(negedge ACLK);
      nvec++;
      if ({mem_en, mem_addr, wreq_ready, rreq_ready} !== {1'b1, 40'h1008, 2'b00}) begin
         nerr++;
         $display("FAIL midreset_beat2: got en=%b addr=%h rdy=%b%b required en=1 addr=1008 rdy=00",
                  mem_en, mem_addr, wreq_ready, rreq_ready);
      end
      @(posedge ACLK); #1;
      ARESET = 1'b0; rreq_valid = 1'b0;
      @(negedge ACLK);
      nvec++;
      if ({mem_en, mem_we, mem_last, busy_w, busy_r, rsv_err, mem_addr} !== 46'b0) begin
         nerr++;
         $display("FAIL midreset_outputs: got en=%b we=%b last=%b bw=%b br=%b rsv=%b addr=%h required all 0",
                  mem_en, mem_we, mem_last, busy_w, busy_r, rsv_err, mem_addr);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge ACLK);
         if (mem_en) replay++;
      end
      nvec++;
      if (replay != 0) begin nerr++; $display("FAIL midreset_replay: got %0d beats required 0", replay); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ARESET = 1'b1; mem_ready = 1'b1;
      wreq_valid = 1'b0; wreq_addr = '0; wreq_len = '0; wreq_size = '0; wreq_burst = '0;
      rreq_valid = 1'b0; rreq_addr = '0; rreq_len = '0; rreq_size = '0; rreq_burst = '0;
      @(posedge ACLK); #1;
      test_reset();
      test_incr_write();
      test_wrap_read();
      test_arbitration();
      test_wraparound();
      test_stall();
      test_illegal();
      test_random();
      test_reset_midburst();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
